// File: rtl/freq_bcd_display.sv
// Converts the frequency meter's 10-bit count to four BCD digits using a sequential
// double-dabble engine, and scans them onto a 4-digit common-anode seven-segment display.
module freq_bcd_display #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  F,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PW = (SCAN_DIV > 32'd1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state_r;
    logic [9:0]     last_r;
    logic [9:0]     cap_r;
    logic [25:0]    shreg_r;
    logic [3:0]     cnt_r;
    logic [PW-1:0]  presc_r;
    logic [1:0]     idx_r;
    logic [3:0]     nib_s;
    logic           blank_s;
    logic [3:0]     an_s;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [25:0] dabble_step(input logic [25:0] v);
        logic [25:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[10 + 4*i +: 4] >= 4'd5) begin
                t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[24:0], 1'b0};
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM; F edits during a conversion are caught by the IDLE compare against last_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            last_r  <= 10'd0;
            cap_r   <= 10'd0;
            shreg_r <= 26'd0;
            cnt_r   <= 4'd0;
            bcd     <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (F != last_r) begin
                        cap_r   <= F;
                        shreg_r <= {16'd0, F};
                        cnt_r   <= 4'd10;
                        busy    <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= dabble_step(shreg_r);
                    cnt_r   <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd     <= shreg_r[25:10];
                    last_r  <= cap_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else if (presc_r == PRESC_MAX) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Select the current digit and decide whether it is a blanked leading zero.
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
        case (idx_r)
            2'd0: begin
                nib_s   = bcd[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                nib_s   = bcd[7:4];
                blank_s = BLANK_LZ && (bcd[15:4] == 12'd0);
            end
            2'd2: begin
                nib_s   = bcd[11:8];
                blank_s = BLANK_LZ && (bcd[15:8] == 8'd0);
            end
            2'd3: begin
                nib_s   = bcd[15:12];
                blank_s = BLANK_LZ && (bcd[15:12] == 4'd0);
            end
            default: begin
                nib_s   = 4'd0;
                blank_s = 1'b0;
            end
        endcase
        an_s = ~(4'b0001 << idx_r);
    end

    // Registered display drive, one cycle behind index and bcd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
        end else begin
            an  <= an_s;
            seg <= blank_s ? 7'h7F : seg_decode(nib_s);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_freq_bcd_display.sv
// Randomized scoreboard bench for freq_bcd_display: an arithmetic reference model predicts
// conversion results, handshake timing and display scan for blanking and non-blanking instances.
module tb_freq_bcd_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  F   = 10'd0;

    logic        busy1, done1, dp1, busy0, done0, dp0;
    logic [15:0] bcd1, bcd0;
    logic [3:0]  an1, an0;
    logic [6:0]  seg1, seg0;

    freq_bcd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .rst(rst), .F(F), .busy(busy1), .done(done1),
        .bcd(bcd1), .an(an1), .seg(seg1), .dp(dp1)
    );

    freq_bcd_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) u_nlz (
        .clk(clk), .rst(rst), .F(F), .busy(busy0), .done(done0),
        .bcd(bcd0), .an(an0), .seg(seg0), .dp(dp0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int         exp_q[$];
    int         m_n    = 0;
    int         m_cnt  = 0;
    int         m_bcd  = 0;
    int         m_pend = 0;
    logic [9:0] m_last = 10'd0;
    logic       m_done = 1'b0;
    logic [3:0] e_an   = 4'hF;
    logic [6:0] e_seg1 = 7'h7F;
    logic [6:0] e_seg0 = 7'h7F;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i, input bit blank);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (blank && i > 0 && v < p) return 7'h7F;
        return seg_tab[(v / p) % 10];
    endfunction

    // Reference model: protocol-level conversion timing and arithmetic display scan.
    always @(posedge clk) begin : model
        int idx;
        if (rst) begin
            m_n = 0; m_cnt = 0; m_bcd = 0; m_last = 10'd0; m_done = 1'b0;
            e_an = 4'hF; e_seg1 = 7'h7F; e_seg0 = 7'h7F;
            exp_q.delete();
        end else begin
            idx    = (m_n / SCAN_DIV) % 4;
            m_n++;
            e_an   = ~(4'b0001 << idx);
            e_seg1 = exp_seg(m_bcd, idx, 1'b1);
            e_seg0 = exp_seg(m_bcd, idx, 1'b0);
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_bcd  = m_pend;
                end
            end else if (F != m_last) begin
                m_last = F;
                m_pend = int'(F);
                m_cnt  = 11;
                exp_q.push_back(int'(F));
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin : monitor
        int v;
        if (rst) begin
            chk("rst_busy", 32'(busy1), 32'd0);
            chk("rst_done", 32'(done1), 32'd0);
            chk("rst_bcd",  32'(bcd1),  32'd0);
            chk("rst_an",   32'(an1),   32'hF);
            chk("rst_seg",  32'(seg1),  32'h7F);
        end else begin
            chk("busy",     32'(busy1), 32'(m_cnt > 0));
            chk("done",     32'(done1), 32'(m_done));
            chk("an",       32'(an1),   32'(e_an));
            chk("seg_lz",   32'(seg1),  32'(e_seg1));
            chk("an_nlz",   32'(an0),   32'(e_an));
            chk("seg_nlz",  32'(seg0),  32'(e_seg0));
            chk("bcd_nlz",  32'(bcd0),  32'(bcd1));
            chk("dp",       32'({dp1, dp0}), 32'd3);
            if (done1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    v = exp_q.pop_front();
                    chk("bcd", 32'(bcd1), 32'(to_bcd(v)));
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
    endtask

    int edge_vals[8] = '{0, 1023, 9, 10, 99, 100, 999, 1000};

    initial begin
        hold(3);
        rst = 1'b0;
        hold(20);
        F = 10'd1023; hold(14);
        F = 10'd57;   hold(20);
        F = 10'd100;  hold(4);
        F = 10'd200;  hold(30);
        F = 10'd999;  hold(6);
        pulse_reset();
        hold(20);
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 2) == 0)
                F = 10'(edge_vals[$urandom_range(0, 7)]);
            else
                F = 10'($urandom_range(0, 1023));
            hold(int'($urandom_range(1, 16)));
            if ($urandom_range(0, 24) == 0) pulse_reset();
        end
        hold(30);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
